// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the bit-serial adder sequencer.
// Latency: none (declarations only).
// Backpressure: not applicable.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit-counter width: must hold the values 0..width.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/fa_cell.sv
// One-bit full adder cell, reused every cycle by the serial sequencer.
// Latency: purely combinational.
// Backpressure: none.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_add_seq.sv
// Bit-serial A+B+Cin using a single full-adder cell, LSB first.
// Latency: busy for WIDTH cycles after the accepting edge, then a one-cycle done.
// Backpressure: start is ignored while busy (no queueing); DONE accepts back-to-back.
module serial_add_seq
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Cout
);

    // The partial-sum register keeps only the upper WIDTH-1 collected bits;
    // the bit that would fall off its LSB is exactly the one that lands in S[0]
    // on the final cycle, so it never needs storing.
    localparam int SW = (WIDTH > 1) ? WIDTH - 1 : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [SW-1:0]    s_sh;
    logic [SW-1:0]    s_sh_next;
    logic [WIDTH-1:0] s_full;
    logic             c;
    logic [CNT_W-1:0] cnt;
    logic             s_bit;
    logic             c_out;

    fa_cell u_fa (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .ci (c),
        .s  (s_bit),
        .co (c_out)
    );

    // Full sum as it would look after this cycle's bit enters the MSB.
    if (WIDTH == 1) begin : g_w1
        assign s_full    = s_bit;
        assign s_sh_next = s_sh;
    end else begin : g_wn
        assign s_full    = {s_bit, s_sh};
        assign s_sh_next = s_full[WIDTH-1:1];
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

    // Sequencer: operand capture, one bit per cycle, result commit on the last bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            s_sh  <= '0;
            c     <= 1'b0;
            cnt   <= '0;
            S     <= '0;
            Cout  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_sh  <= A;
                        b_sh  <= B;
                        c     <= Cin;
                        cnt   <= '0;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    s_sh <= s_sh_next;
                    c    <= c_out;
                    cnt  <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        S     <= s_full;
                        Cout  <= c_out;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_seq.sv
// Randomized and directed bench for serial_add_seq (WIDTH=8 and WIDTH=1 instances).
// Latency: not applicable.
// Backpressure: not applicable.
module tb_serial_add_seq;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, s8;

    logic       start1, cin1, busy1, done1, cout1;
    logic [0:0] a1, b1, s1;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    serial_add_seq #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start8),
        .A     (a8),
        .B     (b8),
        .Cin   (cin8),
        .busy  (busy8),
        .done  (done8),
        .S     (s8),
        .Cout  (cout8)
    );

    serial_add_seq #(.WIDTH(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start1),
        .A     (a1),
        .B     (b1),
        .Cin   (cin1),
        .busy  (busy1),
        .done  (done1),
        .S     (s1),
        .Cout  (cout1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model: a job takes N cycles of busy, then done ----------
    int         l8, l1;          // busy cycles still to go
    bit         d8, d1;          // done expected this cycle
    logic [8:0] p8, h8;          // pending / held result, WIDTH=8
    logic [1:0] p1, h1;          // pending / held result, WIDTH=1
    logic [8:0] q8[$];
    logic [1:0] q1[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l8 = 0; d8 = 0; p8 = '0; h8 = '0; q8.delete();
            l1 = 0; d1 = 0; p1 = '0; h1 = '0; q1.delete();
        end else begin
            if (l8 > 0) begin
                l8--;
                d8 = (l8 == 0);
                if (d8) h8 = p8;
            end else begin
                d8 = 0;
                if (start8) begin
                    p8 = 9'(a8) + 9'(b8) + 9'(cin8);
                    q8.push_back(p8);
                    l8 = 8;
                end
            end
            if (l1 > 0) begin
                l1--;
                d1 = (l1 == 0);
                if (d1) h1 = p1;
            end else begin
                d1 = 0;
                if (start1) begin
                    p1 = 2'(a1) + 2'(b1) + 2'(cin1);
                    q1.push_back(p1);
                    l1 = 1;
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [8:0] e8;
        logic [1:0] e1;
        check("busy8", 32'(busy8), 32'(l8 > 0));
        check("done8", 32'(done8), 32'(d8));
        check("hold8", 32'({cout8, s8}), 32'(h8));
        if (done8 === 1'b1) begin
            if (q8.size() == 0) begin
                n_chk++;
                $display("FAIL sb8: done with no job outstanding at %0t", $time);
            end else begin
                e8 = q8.pop_front();
                check("sb8", 32'({cout8, s8}), 32'(e8));
            end
        end
        check("busy1", 32'(busy1), 32'(l1 > 0));
        check("done1", 32'(done1), 32'(d1));
        check("hold1", 32'({cout1, s1}), 32'(h1));
        if (done1 === 1'b1) begin
            if (q1.size() == 0) begin
                n_chk++;
                $display("FAIL sb1: done with no job outstanding at %0t", $time);
            end else begin
                e1 = q1.pop_front();
                check("sb1", 32'({cout1, s1}), 32'(e1));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic ci);
        a8 = a; b8 = b; cin8 = ci; start8 = 1'b1;
        tick();
        start8 = 1'b0;
    endtask

    task automatic wait_done8(input logic [8:0] exp, input string nm);
        int k = 0;
        while (done8 !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        if (done8 === 1'b1) check(nm, 32'({cout8, s8}), 32'(exp));
        else begin
            n_chk++;
            $display("FAIL %s: no done within 20 cycles", nm);
        end
    endtask

    task automatic wait_done1(input logic [1:0] exp, input string nm);
        int k = 0;
        while (done1 !== 1'b1 && k < 10) begin
            tick();
            k++;
        end
        if (done1 === 1'b1) check(nm, 32'({cout1, s1}), 32'(exp));
        else begin
            n_chk++;
            $display("FAIL %s: no done within 10 cycles", nm);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int nb;
        rst_n = 1'b0;
        start8 = 0; a8 = 0; b8 = 0; cin8 = 0;
        start1 = 0; a1 = 0; b1 = 0; cin1 = 0;
        a8 = 8'hA5; b8 = 8'h5A; cin8 = 1;
        tick(); tick();
        check("rst_busy", 32'(busy8), 0);
        check("rst_done", 32'(done8), 0);
        check("rst_sum",  32'({cout8, s8}), 0);
        #2 rst_n = 1'b1;
        tick(); tick();

        // 1: basic add, busy length and done pulse
        issue8(8'h5A, 8'h3C, 1'b0);
        nb = 0;
        while (busy8 === 1'b1 && nb < 20) begin
            nb++;
            tick();
        end
        check("t1_busylen", 32'(nb), 8);
        check("t1_done", 32'(done8), 1);
        check("t1_sum", 32'({cout8, s8}), 32'h096);
        tick();
        check("t1_done_1cyc", 32'(done8), 0);

        // 2: carry corner cases
        issue8(8'hFF, 8'h01, 1'b0); wait_done8(9'h100, "t2_ff01");
        tick();
        issue8(8'hFF, 8'hFF, 1'b1); wait_done8(9'h1FF, "t2_ffff1");
        tick();
        issue8(8'h00, 8'h00, 1'b0); wait_done8(9'h000, "t2_zero");
        tick();

        // 3: start pulsed during RUN is ignored
        issue8(8'h10, 8'h20, 1'b0);
        tick(); tick();
        a8 = 8'h01; b8 = 8'h01; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        wait_done8(9'h030, "t3_sum");
        tick();
        nb = 0;
        for (int i = 0; i < 12; i++) begin
            if (done8 === 1'b1) nb++;
            tick();
        end
        check("t3_no_extra_done", 32'(nb), 0);

        // 4: start held high with changing operands -> back-to-back jobs
        start8 = 1'b1;
        for (int i = 0; i < 40; i++) begin
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
            tick();
        end
        start8 = 1'b0;
        tick(); tick(); tick(); tick(); tick(); tick(); tick(); tick(); tick(); tick();

        // 5: async reset mid-RUN
        issue8(8'h12, 8'h34, 1'b0); wait_done8(9'h046, "t5_prejob");
        tick();
        issue8(8'h5A, 8'h3C, 1'b0);
        tick(); tick(); tick(); tick();
        check("t5_pre_S", 32'(s8), 32'h46);
        #3 rst_n = 1'b0;
        #1;
        check("t5_busy", 32'(busy8), 0);
        check("t5_done", 32'(done8), 0);
        check("t5_sum",  32'({cout8, s8}), 0);
        #2 rst_n = 1'b1;
        nb = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done8 === 1'b1) nb++;
        end
        check("t5_no_done", 32'(nb), 0);
        issue8(8'h77, 8'h99, 1'b1); wait_done8(9'h111, "t5_after");
        tick();

        // random traffic: random start density, operand churn while busy
        for (int i = 0; i < 400; i++) begin
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
            start8 = ($urandom_range(0, 2) != 0);
            tick();
        end
        start8 = 1'b0;
        for (int i = 0; i < 12; i++) tick();

        // 6: WIDTH=1 instance
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        check("t6_busy", 32'(busy1), 1);
        tick();
        check("t6_busy_end", 32'(busy1), 0);
        check("t6_done", 32'(done1), 1);
        check("t6_sum", 32'({cout1, s1}), 32'h3);
        tick();
        for (int v = 0; v < 8; v++) begin
            logic [2:0] vv;
            vv = 3'(v);
            a1 = vv[2]; b1 = vv[1]; cin1 = vv[0]; start1 = 1'b1;
            tick();
            start1 = 1'b0;
            wait_done1(2'(vv[2]) + 2'(vv[1]) + 2'(vv[0]), "t6_sweep");
            tick();
        end
        start1 = 1'b1;
        for (int i = 0; i < 60; i++) begin
            a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
            start1 = ($urandom_range(0, 3) != 0);
            tick();
        end
        start1 = 1'b0;
        for (int i = 0; i < 6; i++) tick();

        check("q8_drained", 32'(q8.size()), 0);
        check("q1_drained", 32'(q1.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
